// File: rtl/irrig_cmd_encoder.sv
// Operator key front end for the irrigation timer: debounces three
// active-low pushbuttons, encodes presses into 2-bit commands, offers them
// to the controller over a valid/ack handshake and shows the pending or
// last-accepted command on a 7-segment digit.
module irrig_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACK_TIMEOUT     = 50000000,
  parameter int DB_W            = 19,
  parameter int TO_W            = 26
) (
  input  logic       clk_50mhz,
  input  logic       rst_50mhz,
  input  logic [2:0] KEY,
  output logic [1:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ack,
  output logic       err,
  output logic [0:6] HEX0
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_S30   = 2'b10;
  localparam logic [1:0] CMD_S60   = 2'b11;
  localparam logic [1:0] CMD_STOP  = 2'b01;

  // Active-low segments, HEX0[0] = a ... HEX0[6] = g.
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_E     = 7'b0110000;

  typedef enum logic {IDLE, SEND} state_t;

  // One-cycle press pulses, one bit per key (1 = released->pressed).
  logic [2:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;  // debounced level, 1 = pressed
      logic            press_reg;
      logic [DB_W-1:0] cnt_reg;

      // Synchronize the raw key, then accept a level change only after it
      // has been stable for DEBOUNCE_CYCLES consecutive cycles.
      always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= ~KEY[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
            press_reg <= sync2_reg;  // release edges produce no pulse
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  function automatic logic [0:6] seg_of(input logic [1:0] c);
    case (c)
      CMD_S30:  seg_of = SEG_3;
      CMD_S60:  seg_of = SEG_6;
      CMD_STOP: seg_of = SEG_0;
      default:  seg_of = SEG_DASH;
    endcase
  endfunction

  state_t          state_reg, state_next;
  logic [1:0]      cmd_reg, cmd_next;
  logic [1:0]      last_reg, last_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            err_reg, err_next;
  logic            stop_pend_reg, stop_pend_next;
  logic [0:6]      hex_reg, hex_next;
  logic [1:0]      press_cmd;
  logic            any_press;
  logic            stop_override;

  // Encode simultaneous presses with STOP > START60 > START30.
  always_comb begin
    press_cmd = CMD_NONE;
    if (press[2])      press_cmd = CMD_STOP;
    else if (press[1]) press_cmd = CMD_S60;
    else if (press[0]) press_cmd = CMD_S30;
  end

  assign any_press     = |press;
  assign stop_override = press[2] && (cmd_reg != CMD_STOP);

  // Handshake FSM: next state, command, timeout, error and last-accepted.
  always_comb begin
    state_next     = state_reg;
    cmd_next       = cmd_reg;
    last_next      = last_reg;
    to_cnt_next    = to_cnt_reg;
    err_next       = err_reg;
    stop_pend_next = stop_pend_reg;
    if (state_reg == IDLE) begin
      cmd_next = CMD_NONE;
      if (stop_pend_reg || any_press) begin
        state_next     = SEND;
        cmd_next       = stop_pend_reg ? CMD_STOP : press_cmd;
        to_cnt_next    = '0;
        stop_pend_next = 1'b0;
      end
    end else begin
      if (cmd_ack) begin
        // The ack completes the offered command; a STOP arriving in the
        // same cycle is reissued from IDLE right afterwards.
        state_next     = IDLE;
        cmd_next       = CMD_NONE;
        err_next       = 1'b0;
        last_next      = cmd_reg;
        to_cnt_next    = '0;
        stop_pend_next = stop_override;
      end else if (to_cnt_reg == TO_LAST) begin
        state_next  = IDLE;
        cmd_next    = CMD_NONE;
        err_next    = 1'b1;
        to_cnt_next = '0;
      end else if (stop_override) begin
        cmd_next    = CMD_STOP;
        to_cnt_next = '0;
      end else begin
        to_cnt_next = to_cnt_reg + 1'b1;
      end
    end
  end

  // Display source: pending command in SEND, else error or last-accepted.
  always_comb begin
    hex_next = seg_of(last_reg);
    if (state_reg == SEND) hex_next = seg_of(cmd_reg);
    else if (err_reg)      hex_next = SEG_E;
  end

  // State and output registers.
  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      state_reg     <= IDLE;
      cmd_reg       <= CMD_NONE;
      last_reg      <= CMD_NONE;
      to_cnt_reg    <= '0;
      err_reg       <= 1'b0;
      stop_pend_reg <= 1'b0;
      hex_reg       <= SEG_DASH;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      last_reg      <= last_next;
      to_cnt_reg    <= to_cnt_next;
      err_reg       <= err_next;
      stop_pend_reg <= stop_pend_next;
      hex_reg       <= hex_next;
    end
  end

  assign cmd       = cmd_reg;
  assign cmd_valid = (state_reg == SEND);
  assign err       = err_reg;
  assign HEX0      = hex_reg;

endmodule
